dst_stream_out: RTL
===================

Name: dst_stream_out

Overview:
- Downstream consumer of the batch controller's dst read port.
- Accepts accumulator words from the dst buffer via dst_valid/dst_ready.
- Per word: arithmetic right shift, optional ReLU, saturation to OW bits.
- Packs PACK results per beat and drives an AXI4-Stream master with tlast at frame end.
- Output goes to the DMA write channel.

Parameters:
- DW, 32, dst_data width (signed accumulator).
- OW, 16, output element width (signed).
- PACK, 2, elements per output beat; power of two, 1..4.
- DEPTH, 4, output FIFO entries in beats; fixed minimum 4.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- run  input  1  enable; low = synchronous clear of all state except configuration
- relu  input  1  clamp negative results to 0
- shift  input  5  arithmetic right-shift amount
- frame_len  input  10  input words per frame minus 1
- dst_valid  input  1  dst_data valid
- dst_data  input  DW  signed accumulator word
- dst_ready  output  1  block can accept a word
- m_tvalid  output  1  AXI-S valid
- m_tdata  output  OW*PACK  packed beat
- m_tlast  output  1  last beat of frame
- m_tready  input  1  AXI-S ready
- frame_done  output  1  one-cycle pulse on the tlast handshake
- busy  output  1  frame in progress or FIFO non-empty

Behaviour:
- Reset (or run=0): dst_ready=0, m_tvalid=0, m_tdata=0, m_tlast=0, frame_done=0, busy=0. FIFO emptied; word counter wc=0; lane index li=0; stage-1 valid s1_v=0.
- Accept: a word is accepted when dst_valid & dst_ready.
- dst_ready = run & (fifo_cnt + s1_v <= DEPTH-2). It is a function of registers only, not of dst_valid or m_tready.
- Stage 1 (edge after accept):
  - s1 <= sat(relu ? max(y,0) : y), where y = dst_data >>> shift.
  - s1_last <= (wc == frame_len).
  - wc increments; it wraps to 0 after frame_len.
- Saturation: clamp to [-2^(OW-1), 2^(OW-1)-1]. Computed at DW bits, then truncated.
- Stage 2 (packer, when s1_v):
  - s1 is written to lane li, bits [OW*li +: OW].
  - If li==PACK-1 or s1_last: push the beat {lanes, tlast=s1_last} to the FIFO, reset li=0, clear the lanes. Unwritten upper lanes are 0.
  - Otherwise li increments.
- Latency: accept at edge t → earliest m_tvalid in cycle t+2 (PACK=1, empty FIFO).
- Throughput: one word per cycle when m_tready=1.
- FIFO: pops on m_tvalid & m_tready. m_tvalid/m_tdata/m_tlast come from the head entry and stay stable while m_tready=0.
- Simultaneous push and pop: fifo_cnt unchanged.
- Overflow is impossible by construction of dst_ready. The bench asserts this.
- frame_done is registered; it pulses in the cycle after the tlast handshake.
- busy = (wc!=0) | (li!=0) | s1_v | (fifo_cnt!=0).
- run dropping mid-frame: partial beat and FIFO contents are discarded, with no tlast emitted. The next frame starts at wc=0, li=0.
- shift, relu and frame_len must be stable while busy. Changing them mid-frame is undefined.
- frame_len=0: a single-word frame produces one beat with tlast.

Decomposition:
- Shared package (batch_pkg): DW/OW defaults, the sat_shift function (shift, ReLU, clamp), and the beat struct {data[OW*PACK], last}.
- One sub-module: stream_fifo. Synchronous, parameterised width/depth, with count output and first-word-fall-through head.

Test Plan:
- PACK=2, shift=4, relu=0, frame_len=3, data 0x100, 0x200, -0x100, 0x7FFFFFFF, m_tready=1 → beats 0x00200010 (tlast=0), then 0x7FFFFFF0 (tlast=1); frame_done pulses once.
- Same stimulus with relu=1 → second beat 0x7FFF0000; first beat unchanged.
- PACK=2, frame_len=2, shift=0, data 1, 2, 3 → beats 0x00020001 and 0x00000003 (tlast=1); the upper lane is zero-padded.
- Saturation, shift=0: 0x80000000 → 0x8000; 0x00008000 → 0x7FFF; 0xFFFF8000 → 0x8000.
- Backpressure: continuous dst_valid, m_tready=0 for 12 cycles.
  - dst_ready deasserts once fifo_cnt+s1_v>2.
  - m_tdata holds steady.
  - After release, all words are emitted in order with no loss or duplication, checked against a scoreboard.
- Drop run for 1 cycle after 5 of 8 words.
  - Next cycle: m_tvalid=0, dst_ready=0, busy=0.
  - The following frame of 8 words yields exactly 4 beats (PACK=2), the first starting at lane 0.

Source files
------------

// File: rtl/batch_pkg.sv
// Shared definitions for the batch datapath: default widths, the output beat
// record and the shift/ReLU/saturate arithmetic applied to accumulator words.
package batch_pkg;

    localparam int DW_DEF   = 32;
    localparam int OW_DEF   = 16;
    localparam int PACK_DEF = 2;

    typedef struct packed {
        logic [OW_DEF*PACK_DEF-1:0] data;
        logic                       last;
    } beat_t;

    // Operand arrives sign-extended to 64 bits so one routine serves any DW up to 64.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] x,
        input logic [4:0]         sh,
        input logic               relu_en,
        input int                 ow
    );
        logic signed [63:0] y;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        y = x >>> sh;
        if (relu_en && (y < 64'sd0)) begin
            y = 64'sd0;
        end else begin
            y = y;
        end
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ow - 1));
        if (y > hi) begin
            r = hi;
        end else if (y < lo) begin
            r = lo;
        end else begin
            r = y;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with first-word-fall-through head and occupancy count.
// The head reads as zero while empty so downstream sees clean idle data.
module stream_fifo #(
    parameter int W     = 33,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= (wr_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= (rd_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : rd_ptr_r + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = (count_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : {W{1'b0}};
    assign count = count_r;

endmodule

// File: rtl/dst_stream_out.sv
// Drains accumulator words from the dst buffer, rescales each to OW bits and
// packs PACK of them per AXI4-Stream beat, marking the frame's final beat.
module dst_stream_out
    import batch_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int OW    = OW_DEF,
    parameter int PACK  = PACK_DEF,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               relu,
    input  logic [4:0]         shift,
    input  logic [9:0]         frame_len,
    input  logic               dst_valid,
    input  logic [DW-1:0]      dst_data,
    output logic               dst_ready,
    output logic               m_tvalid,
    output logic [OW*PACK-1:0] m_tdata,
    output logic               m_tlast,
    input  logic               m_tready,
    output logic               frame_done,
    output logic               busy
);

    localparam int BW  = OW * PACK;
    localparam int LIW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    logic                 accept_s;
    logic signed [63:0]   sat_full_s;
    logic [OW-1:0]        sat_s;
    logic [OW-1:0]        s1_r;
    logic                 s1_v_r;
    logic                 s1_last_r;
    logic [9:0]           wc_r;
    logic [LIW-1:0]       li_r;
    logic [BW-1:0]        lanes_r;
    logic [BW-1:0]        merged_s;
    logic                 push_s;
    logic                 pop_s;
    logic [BW:0]          head_s;
    logic [CW-1:0]        fifo_cnt_s;
    logic                 room_s;
    logic                 frame_done_r;

    // Rescale the incoming word and measure space left for in-flight words
    always_comb begin
        sat_full_s = sat_shift(64'(signed'(dst_data)), shift, relu, OW);
        sat_s      = sat_full_s[OW-1:0];
        room_s     = (int'(fifo_cnt_s) + int'(s1_v_r)) <= (DEPTH - 2);
    end

    assign dst_ready = run & room_s;
    assign accept_s  = dst_valid & dst_ready;

    // Stage 1: registered rescaled word, end-of-frame flag and word counter
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            s1_r      <= {OW{1'b0}};
            s1_v_r    <= 1'b0;
            s1_last_r <= 1'b0;
            wc_r      <= 10'd0;
        end else begin
            s1_v_r <= accept_s;
            if (accept_s) begin
                s1_r      <= sat_s;
                s1_last_r <= (wc_r == frame_len);
                wc_r      <= (wc_r == frame_len) ? 10'd0 : wc_r + 10'd1;
            end
        end
    end

    // Current word merged into the partially built beat
    always_comb begin
        merged_s               = lanes_r;
        merged_s[OW*li_r +: OW] = s1_r;
        push_s                 = s1_v_r & ((li_r == LIW'(PACK - 1)) | s1_last_r);
    end

    // Stage 2: lane packer; a beat closes on a full lane set or the frame's last word
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            li_r    <= {LIW{1'b0}};
            lanes_r <= {BW{1'b0}};
        end else if (s1_v_r) begin
            if (push_s) begin
                li_r    <= {LIW{1'b0}};
                lanes_r <= {BW{1'b0}};
            end else begin
                li_r    <= li_r + LIW'(1);
                lanes_r <= merged_s;
            end
        end else begin
            li_r    <= li_r;
            lanes_r <= lanes_r;
        end
    end

    assign pop_s = m_tvalid & m_tready;

    stream_fifo #(
        .W     (BW + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (!run),
        .push      (push_s),
        .push_data ({merged_s, s1_last_r}),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_cnt_s)
    );

    // Frame completion pulse, one cycle after the tlast handshake
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= pop_s & m_tlast;
        end
    end

    assign m_tvalid   = (fifo_cnt_s != {CW{1'b0}});
    assign m_tdata    = head_s[BW:1];
    assign m_tlast    = head_s[0];
    assign frame_done = frame_done_r;
    assign busy       = (wc_r != 10'd0) | (li_r != {LIW{1'b0}}) | s1_v_r | (fifo_cnt_s != {CW{1'b0}});

endmodule
